// File: rtl/recibidor_pcie_pkg.sv
// Shared constants and types for the serial receive path.
// Holds the symbol width, the K28.5 comma patterns as they appear in the shift
// window (bit 9 = j ... bit 0 = a), the lane-width encodings and the decoded
// symbol payload.
package recibidor_pcie_pkg;

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned BYTE_W = 8;

  localparam logic [SYM_W-1:0] K285_RDN = 10'b0101111100;
  localparam logic [SYM_W-1:0] K285_RDP = 10'b1010000011;

  typedef enum logic [1:0] {
    W8  = 2'b00,
    W16 = 2'b01,
    W32 = 2'b10
  } anchoSel_e;

  typedef struct packed {
    logic              k;
    logic              err;
    logic [BYTE_W-1:0] dato;
  } simbolo_t;

  // 2'b11 is not a defined width and falls back to the byte lane
  function automatic anchoSel_e normAncho(input logic [1:0] sel);
    return (sel == 2'b11) ? W8 : anchoSel_e'(sel);
  endfunction

endpackage

// File: rtl/recibidor_pcie_decodificador_8b10b.sv
// Combinational 8b/10b decoder: 10-bit code group -> {K flag, error, byte}.
// Ports: simbolo  window contents, bit 0 = a ... bit 9 = j
//        decod_c  decoded byte HGFEDCBA, K flag, invalid-code flag
// Both disparity forms are accepted; running disparity is not tracked.
module decodificador_8b10b
  import recibidor_pcie_pkg::*;
(
  input  logic [SYM_W-1:0] simbolo,
  output simbolo_t         decod_c
);

  logic [5:0] sb6;
  logic [3:0] sb4;
  logic [4:0] edcba;
  logic [2:0] hgf;
  logic       ok6;
  logic       ok4;
  logic       kOk;
  logic [7:0] kDato;

  always_comb begin
    sb6   = {simbolo[0], simbolo[1], simbolo[2], simbolo[3], simbolo[4], simbolo[5]};
    sb4   = {simbolo[6], simbolo[7], simbolo[8], simbolo[9]};
    edcba = 5'd0;
    hgf   = 3'd0;
    ok6   = 1'b1;
    ok4   = 1'b1;
    kOk   = 1'b1;
    kDato = 8'h00;

    // 5b/6b data table, literals written abcdei
    case (sb6)
      6'b100111, 6'b011000: edcba = 5'd0;
      6'b011101, 6'b100010: edcba = 5'd1;
      6'b101101, 6'b010010: edcba = 5'd2;
      6'b110001:            edcba = 5'd3;
      6'b110101, 6'b001010: edcba = 5'd4;
      6'b101001:            edcba = 5'd5;
      6'b011001:            edcba = 5'd6;
      6'b111000, 6'b000111: edcba = 5'd7;
      6'b111001, 6'b000110: edcba = 5'd8;
      6'b100101:            edcba = 5'd9;
      6'b010101:            edcba = 5'd10;
      6'b110100:            edcba = 5'd11;
      6'b001101:            edcba = 5'd12;
      6'b101100:            edcba = 5'd13;
      6'b011100:            edcba = 5'd14;
      6'b010111, 6'b101000: edcba = 5'd15;
      6'b011011, 6'b100100: edcba = 5'd16;
      6'b100011:            edcba = 5'd17;
      6'b010011:            edcba = 5'd18;
      6'b110010:            edcba = 5'd19;
      6'b001011:            edcba = 5'd20;
      6'b101010:            edcba = 5'd21;
      6'b011010:            edcba = 5'd22;
      6'b111010, 6'b000101: edcba = 5'd23;
      6'b110011, 6'b001100: edcba = 5'd24;
      6'b100110:            edcba = 5'd25;
      6'b010110:            edcba = 5'd26;
      6'b110110, 6'b001001: edcba = 5'd27;
      6'b001110:            edcba = 5'd28;
      6'b101110, 6'b010001: edcba = 5'd29;
      6'b011110, 6'b100001: edcba = 5'd30;
      6'b101011, 6'b010100: edcba = 5'd31;
      default:              ok6   = 1'b0;
    endcase

    // 3b/4b data table, literals written fghj; the alternate .7 form is only
    // legal after the six 5b codes that would otherwise produce a run of five
    case (sb4)
      4'b1011, 4'b0100: hgf = 3'd0;
      4'b1001:          hgf = 3'd1;
      4'b0101:          hgf = 3'd2;
      4'b1100, 4'b0011: hgf = 3'd3;
      4'b1101, 4'b0010: hgf = 3'd4;
      4'b1010:          hgf = 3'd5;
      4'b0110:          hgf = 3'd6;
      4'b1110, 4'b0001: hgf = 3'd7;
      4'b0111, 4'b1000: begin
        hgf = 3'd7;
        ok4 = (edcba == 5'd17) || (edcba == 5'd18) || (edcba == 5'd20) ||
              (edcba == 5'd11) || (edcba == 5'd13) || (edcba == 5'd14);
      end
      default:          ok4 = 1'b0;
    endcase

    // K codes matched as whole groups: the K28 4b sub-block meaning depends on
    // which 6b form precedes it
    case ({sb6, sb4})
      10'b0011110100, 10'b1100001011: kDato = 8'h1C;
      10'b0011111001, 10'b1100000110: kDato = 8'h3C;
      10'b0011110101, 10'b1100001010: kDato = 8'h5C;
      10'b0011110011, 10'b1100001100: kDato = 8'h7C;
      10'b0011110010, 10'b1100001101: kDato = 8'h9C;
      10'b0011111010, 10'b1100000101: kDato = 8'hBC;
      10'b0011110110, 10'b1100001001: kDato = 8'hDC;
      10'b0011111000, 10'b1100000111: kDato = 8'hFC;
      10'b1110101000, 10'b0001010111: kDato = 8'hF7;
      10'b1101101000, 10'b0010010111: kDato = 8'hFB;
      10'b1011101000, 10'b0100010111: kDato = 8'hFD;
      10'b0111101000, 10'b1000010111: kDato = 8'hFE;
      default:                        kOk   = 1'b0;
    endcase

    decod_c = '0;
    if (kOk) begin
      decod_c.k    = 1'b1;
      decod_c.dato = kDato;
    end else if (ok6 && ok4) begin
      decod_c.dato = {hgf, edcba};
    end else begin
      decod_c.err  = 1'b1;
    end
  end

endmodule

// File: rtl/recibidor_pcie.sv
// Serial receive path: bit shifter, K28.5 comma alignment, 8b/10b decode and
// 8/16/32-bit word assembly.
// Ports: clkRx, rst (async, active-high), enb (hold when 0), serialIn (a first),
//        dataS (00=8, 01=16, 10=32, 11=8), dataOut8/16/32 last byte/words,
//        k_out last symbol was control, error_probable last symbol invalid.
module recibidor_pcie
  import recibidor_pcie_pkg::*;
(
  input  logic        clkRx,
  input  logic        rst,
  input  logic        enb,
  input  logic        serialIn,
  input  logic [1:0]  dataS,
  output logic [7:0]  dataOut8,
  output logic [15:0] dataOut16,
  output logic [31:0] dataOut32,
  output logic        k_out,
  output logic        error_probable
);

  logic [SYM_W-1:0] ventana;
  logic [SYM_W-1:0] ventanaSig_c;
  logic             alineado;
  logic [3:0]       cuentaBits;
  logic [1:0]       cuentaLane;
  logic [23:0]      staging;
  logic             simboloListo;
  logic             comaListo;
  anchoSel_e        anchoPrev;
  anchoSel_e        anchoAct_c;
  simbolo_t         decod_c;
  logic             esComa_c;
  logic             fin_c;
  logic             cambioAncho_c;
  logic [1:0]       lane_c;

  // Window is stable from the completing edge until the next enabled edge,
  // so the decoder reads the register directly one edge later.
  decodificador_8b10b uDecod (
    .simbolo (ventana),
    .decod_c (decod_c)
  );

  assign ventanaSig_c  = {serialIn, ventana[SYM_W-1:1]};
  assign esComa_c      = (ventanaSig_c == K285_RDN) || (ventanaSig_c == K285_RDP);
  assign fin_c         = esComa_c || (alineado && (cuentaBits == 4'(SYM_W - 1)));
  assign anchoAct_c    = normAncho(dataS);
  assign cambioAncho_c = (anchoAct_c != anchoPrev);
  // A comma, or a fresh width selection, always starts a new word at lane 0
  assign lane_c        = (comaListo || cambioAncho_c) ? 2'd0 : cuentaLane;

  always_ff @(posedge clkRx or posedge rst) begin
    if (rst) begin
      ventana        <= '0;
      alineado       <= 1'b0;
      cuentaBits     <= 4'd0;
      cuentaLane     <= 2'd0;
      staging        <= 24'd0;
      simboloListo   <= 1'b0;
      comaListo      <= 1'b0;
      anchoPrev      <= W8;
      dataOut8       <= 8'd0;
      dataOut16      <= 16'd0;
      dataOut32      <= 32'd0;
      k_out          <= 1'b0;
      error_probable <= 1'b0;
    end else if (enb) begin
      ventana      <= ventanaSig_c;
      simboloListo <= fin_c;
      comaListo    <= esComa_c;
      anchoPrev    <= anchoAct_c;

      if (esComa_c)
        alineado <= 1'b1;

      if (fin_c)
        cuentaBits <= 4'd0;
      else if (alineado)
        cuentaBits <= cuentaBits + 4'd1;

      if (cambioAncho_c) begin
        cuentaLane <= 2'd0;
        staging    <= 24'd0;
      end

      // Publish the symbol completed on the previous enabled edge
      if (simboloListo) begin
        dataOut8       <= decod_c.dato;
        k_out          <= decod_c.k;
        error_probable <= decod_c.err;
        case (anchoAct_c)
          W16: begin
            if (lane_c == 2'd1) begin
              dataOut16  <= {decod_c.dato, staging[7:0]};
              cuentaLane <= 2'd0;
            end else begin
              staging[7:0] <= decod_c.dato;
              cuentaLane   <= 2'd1;
            end
          end
          W32: begin
            if (lane_c == 2'd3) begin
              dataOut32  <= {decod_c.dato, staging};
              cuentaLane <= 2'd0;
            end else begin
              staging[8*lane_c +: 8] <= decod_c.dato;
              cuentaLane             <= lane_c + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_recibidor_pcie.sv
// Directed bench for recibidor_pcie: symbols are driven bit-serially (a first)
// and outputs are compared against hand-decoded constants.
module tb_recibidor_pcie;

  logic        clkRx;
  logic        rst;
  logic        enb;
  logic        serialIn;
  logic [1:0]  dataS;
  logic [7:0]  dataOut8;
  logic [15:0] dataOut16;
  logic [31:0] dataOut32;
  logic        k_out;
  logic        error_probable;

  int unsigned cuentas;
  int unsigned errores;

  // Symbols in transmit order: MSB = a (sent first) ... LSB = j
  localparam logic [9:0] S_K285 = 10'b0011111010;
  localparam logic [9:0] S_D215 = 10'b1010101010;
  localparam logic [9:0] S_D102 = 10'b0101010101;
  localparam logic [9:0] S_CERO = 10'b0000000000;

  recibidor_pcie dut (
    .clkRx          (clkRx),
    .rst            (rst),
    .enb            (enb),
    .serialIn       (serialIn),
    .dataS          (dataS),
    .dataOut8       (dataOut8),
    .dataOut16      (dataOut16),
    .dataOut32      (dataOut32),
    .k_out          (k_out),
    .error_probable (error_probable)
  );

  initial clkRx = 1'b0;
  always #5 clkRx = ~clkRx;

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    cuentas++;
    if (obs !== esp) begin
      errores++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
    end
  endtask

  task automatic sendBit(input logic b);
    @(negedge clkRx);
    serialIn = b;
    enb      = 1'b1;
    @(posedge clkRx);
    #1;
  endtask

  task automatic sendSym(input logic [9:0] sym);
    for (int i = 0; i < 10; i++) sendBit(sym[9-i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clkRx);
      enb      = 1'b0;
      serialIn = 1'($urandom_range(0, 1));
      @(posedge clkRx);
      #1;
    end
  endtask

  task automatic doReset(input logic [1:0] sel);
    @(negedge clkRx);
    rst   = 1'b1;
    enb   = 1'b0;
    dataS = sel;
    repeat (2) @(negedge clkRx);
    rst = 1'b0;
  endtask

  task automatic chkTodoCero(input string tag);
    chequear({tag, "_d8"},  32'(dataOut8),       32'h0);
    chequear({tag, "_d16"}, 32'(dataOut16),      32'h0);
    chequear({tag, "_d32"}, dataOut32,           32'h0);
    chequear({tag, "_k"},   32'(k_out),          32'h0);
    chequear({tag, "_err"}, 32'(error_probable), 32'h0);
  endtask

  initial begin
    logic [3:0] hist;
    logic       b;
    logic [9:0] sym;

    cuentas  = 0;
    errores  = 0;
    rst      = 1'b1;
    enb      = 1'b1;
    dataS    = 2'b00;
    serialIn = 1'b0;

    // Reset held 100 ns with a noisy line
    for (int i = 0; i < 10; i++) begin
      @(negedge clkRx);
      serialIn = 1'($urandom_range(0, 1));
    end
    #1;
    chkTodoCero("reset");
    @(negedge clkRx);
    rst = 1'b0;

    // Random bits with no run of five equal bits can never contain a comma
    hist = 4'b0000;
    for (int i = 0; i < 60; i++) begin
      b = 1'($urandom_range(0, 1));
      if (hist == 4'b1111 && b)  b = 1'b0;
      if (hist == 4'b0000 && !b) b = 1'b1;
      hist = {hist[2:0], b};
      sendBit(b);
    end
    chkTodoCero("nocomma");

    // Byte lane: K28.5 then D21.5
    doReset(2'b00);
    sendSym(S_K285);
    chequear("w8_lat", 32'(dataOut8), 32'h00);
    sendSym(S_D215);
    chequear("w8_k_d8",  32'(dataOut8),       32'hBC);
    chequear("w8_k_k",   32'(k_out),          32'h1);
    chequear("w8_k_err", 32'(error_probable), 32'h0);
    sendSym(S_D215);
    chequear("w8_d_d8",  32'(dataOut8),       32'hB5);
    chequear("w8_d_k",   32'(k_out),          32'h0);
    chequear("w8_d_err", 32'(error_probable), 32'h0);

    // 16-bit: word appears only once the second byte is published
    doReset(2'b01);
    sendSym(S_K285);
    sendSym(S_D215);
    chequear("w16_early", 32'(dataOut16), 32'h0000);
    sendBit(1'b1);
    chequear("w16_word", 32'(dataOut16), 32'hB5BC);

    // 16-bit: a comma mid-word restarts at lane 0
    doReset(2'b01);
    sendSym(S_K285);
    sendSym(S_D215);
    sendSym(S_D102);
    sendSym(S_K285);
    sendSym(S_D102);
    chequear("w16_realign_hold", 32'(dataOut16), 32'hB5BC);
    sendSym(S_D215);
    chequear("w16_realign_word", 32'(dataOut16), 32'h4ABC);

    // 32-bit assembly
    doReset(2'b10);
    sendSym(S_K285);
    sendSym(S_D215);
    sendSym(S_D102);
    sendSym(S_D215);
    chequear("w32_early", dataOut32, 32'h0);
    chequear("w32_d8_mid", 32'(dataOut8), 32'h4A);
    sendSym(S_D215);
    chequear("w32_word", dataOut32, 32'hB54AB5BC);
    chequear("w32_d8", 32'(dataOut8), 32'hB5);
    chequear("w32_d16", 32'(dataOut16), 32'h0);

    // Invalid code group and recovery
    doReset(2'b00);
    sendSym(S_K285);
    sendSym(S_CERO);
    chequear("inv_pre", 32'(dataOut8), 32'hBC);
    sendSym(S_D215);
    chequear("inv_err", 32'(error_probable), 32'h1);
    chequear("inv_d8",  32'(dataOut8),       32'h00);
    chequear("inv_k",   32'(k_out),          32'h0);
    sendSym(S_D215);
    chequear("rec_err", 32'(error_probable), 32'h0);
    chequear("rec_d8",  32'(dataOut8),       32'hB5);

    // enb pauses: right after the comma and in the middle of D21.5
    doReset(2'b00);
    sendSym(S_K285);
    idle(7);
    chequear("pause_hold", 32'(dataOut8), 32'h00);
    sym = S_D215;
    for (int i = 0; i < 4; i++) sendBit(sym[9-i]);
    chequear("pause_k", 32'(dataOut8), 32'hBC);
    idle(7);
    chequear("pause_mid", 32'(dataOut8), 32'hBC);
    for (int i = 4; i < 10; i++) sendBit(sym[9-i]);
    chequear("pause_notyet", 32'(dataOut8), 32'hBC);
    sendBit(1'b1);
    chequear("pause_d8", 32'(dataOut8), 32'hB5);
    chequear("pause_k0", 32'(k_out),    32'h0);

    // Reset mid-symbol drops alignment; data without a comma stays silent
    doReset(2'b00);
    sendSym(S_K285);
    for (int i = 0; i < 3; i++) sendBit(sym[9-i]);
    doReset(2'b00);
    sendSym(S_D215);
    sendSym(S_D215);
    sendSym(S_D215);
    chequear("rst_mid_d8", 32'(dataOut8), 32'h00);
    chequear("rst_mid_k",  32'(k_out),    32'h0);

    $display("Result: errors=%0d of %0d checks", errores, cuentas);
    $finish;
  end

endmodule
